// File: rtl/RingBufferPkg.sv
// Shared types and pointer arithmetic for the transactional ring buffer.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
package RingBufferPkg;

  typedef enum logic {
    TXN_IDLE = 1'b0,
    TXN_OPEN = 1'b1
  } txn_state_t;

  // Difference a - b, taken modulo 2**ptrW.
  function automatic int unsigned ptrDiff(input int unsigned a, input int unsigned b,
                                          input int unsigned ptrW);
    return (a - b) & ((32'd1 << ptrW) - 32'd1);
  endfunction

endpackage

// File: rtl/ring_buffer_ram.sv
// Simple dual-port storage for the ring buffer: one synchronous write port
// and one synchronous read port. The array has no reset, so it maps onto block RAM.
module ring_buffer_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    if (rdEn) rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/ring_buffer_txn.sv
// Transactional ring buffer: producer pushes words, consumer pops them, and
// reads made inside an open transaction can be committed or rolled back.
module ring_buffer_txn
  import RingBufferPkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [DATA_W-1:0] pushData,
  input  logic              pushRequest,
  output logic              pushDone,
  output logic [DATA_W-1:0] popData,
  input  logic              popRequest,
  output logic              popDone,
  input  logic              open,
  input  logic              commit,
  input  logic              rollback,
  output logic [ADDR_W:0]   memUsed,
  output logic              txnOpen,
  output logic              overflow,
  output txn_state_t        dbgState
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int DEPTH = 2**ADDR_W;

  // Handshake: a request is held high until its done pulse. A request is
  // taken in the cycle it is seen with done low; done pulses high the next
  // cycle, during which the still-high request is ignored. If the request is
  // still high in the cycle after the done pulse it is a new request.

  logic [PTR_W-1:0]  wrPtr, rdWork, rdCommit, usedNow;
  logic [DATA_W-1:0] ramRdData;
  txn_state_t        state;
  logic              full, avail, pushFire, popFire, restart;

  assign usedNow  = PTR_W'(ptrDiff(32'(wrPtr), 32'(rdCommit), 32'(PTR_W)));
  assign full     = (usedNow == PTR_W'(DEPTH));
  assign avail    = (wrPtr != rdWork);
  assign pushFire = pushRequest && !pushDone;
  // Rollback or restart rewinds rdWork, so a pop in that cycle waits a cycle.
  assign restart  = (state == TXN_OPEN) && !commit && (rollback || open);
  assign popFire  = popRequest && !popDone && avail && !restart;

  assign popData  = popDone ? ramRdData : '0;
  assign txnOpen  = (state == TXN_OPEN);
  assign dbgState = state;

  ring_buffer_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .wrEn   (pushFire && !full),
    .wrAddr (wrPtr[ADDR_W-1:0]),
    .wrData (pushData),
    .rdEn   (popFire),
    .rdAddr (rdWork[ADDR_W-1:0]),
    .rdData (ramRdData)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wrPtr    <= '0;
      rdWork   <= '0;
      rdCommit <= '0;
      memUsed  <= '0;
      pushDone <= 1'b0;
      popDone  <= 1'b0;
      overflow <= 1'b0;
      state    <= TXN_IDLE;
    end else begin
      pushDone <= pushFire;
      overflow <= pushFire && full;
      popDone  <= popFire;
      memUsed  <= usedNow;
      if (pushFire && !full) wrPtr <= wrPtr + PTR_W'(1);
      if (popFire) rdWork <= rdWork + PTR_W'(1);

      case (state)
        TXN_IDLE: begin
          // A pop in the same cycle as open belongs to the new transaction.
          if (open) state <= TXN_OPEN;
          else if (popFire) rdCommit <= rdWork + PTR_W'(1);
        end
        TXN_OPEN: begin
          if (commit) begin
            rdCommit <= popFire ? rdWork + PTR_W'(1) : rdWork;
            state    <= TXN_IDLE;
          end else if (rollback) begin
            rdWork <= rdCommit;
            state  <= TXN_IDLE;
          end else if (open) begin
            rdWork <= rdCommit;
          end
        end
        default: state <= TXN_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_buffer_txn.sv
// Self-checking bench for ring_buffer_txn with a 4-word buffer; popped words
// are checked against an expected queue filled as words are pushed.
module tb_ring_buffer_txn;
  import RingBufferPkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;

  logic              clk;
  logic              nRst;
  logic [DATA_W-1:0] pushData;
  logic              pushRequest;
  logic              pushDone;
  logic [DATA_W-1:0] popData;
  logic              popRequest;
  logic              popDone;
  logic              open;
  logic              commit;
  logic              rollback;
  logic [ADDR_W:0]   memUsed;
  logic              txnOpen;
  logic              overflow;
  txn_state_t        dbgState;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] txnRead[$];
  int                testsRun;
  int                testsFailed;

  ring_buffer_txn #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk         (clk),
    .nRst        (nRst),
    .pushData    (pushData),
    .pushRequest (pushRequest),
    .pushDone    (pushDone),
    .popData     (popData),
    .popRequest  (popRequest),
    .popDone     (popDone),
    .open        (open),
    .commit      (commit),
    .rollback    (rollback),
    .memUsed     (memUsed),
    .txnOpen     (txnOpen),
    .overflow    (overflow),
    .dbgState    (dbgState)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: every popDone consumes the oldest expected word.
  always @(negedge clk) begin
    logic [DATA_W-1:0] expWord;
    if (nRst && popDone) begin
      testsRun++;
      if (exp_q.size() == 0) begin
        testsFailed++;
        $display("FAIL pop_unexpected: popData=%h, required no popDone", popData);
      end else begin
        expWord = exp_q.pop_front();
        txnRead.push_back(expWord);
        if (popData !== expWord) begin
          testsFailed++;
          $display("FAIL pop_data: popData=%h, required %h", popData, expWord);
        end
      end
    end
  end

  // Driver tasks
  task automatic doPush(input logic [DATA_W-1:0] d, output bit done, output bit ovf);
    done = 1'b0;
    ovf  = 1'b0;
    @(posedge clk); #1;
    pushData    = d;
    pushRequest = 1'b1;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (pushDone) begin
        done = 1'b1;
        ovf  = overflow;
      end
    end
    @(posedge clk); #1;
    pushRequest = 1'b0;
  endtask

  task automatic doPop(input int budget, output bit done);
    done = 1'b0;
    @(posedge clk); #1;
    popRequest = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (popDone) done = 1'b1;
    end
    @(posedge clk); #1;
    popRequest = 1'b0;
  endtask

  task automatic doOpen();
    txnRead.delete();
    @(posedge clk); #1 open = 1'b1;
    @(posedge clk); #1 open = 1'b0;
  endtask

  task automatic doCommit();
    txnRead.delete();
    @(posedge clk); #1 commit = 1'b1;
    @(posedge clk); #1 commit = 1'b0;
  endtask

  task automatic doRollback();
    for (int i = txnRead.size() - 1; i >= 0; i--) exp_q.push_front(txnRead[i]);
    txnRead.delete();
    @(posedge clk); #1 rollback = 1'b1;
    @(posedge clk); #1 rollback = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  // Scenarios
  task automatic test_reset();
    #2;
    testsRun += 7;
    if (pushDone !== 1'b0) begin testsFailed++; $display("FAIL reset_pushDone: got %b, required 0", pushDone); end
    if (popDone !== 1'b0) begin testsFailed++; $display("FAIL reset_popDone: got %b, required 0", popDone); end
    if (overflow !== 1'b0) begin testsFailed++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    if (txnOpen !== 1'b0) begin testsFailed++; $display("FAIL reset_txnOpen: got %b, required 0", txnOpen); end
    if (memUsed !== 3'd0) begin testsFailed++; $display("FAIL reset_memUsed: got %0d, required 0", memUsed); end
    if (popData !== 16'h0) begin testsFailed++; $display("FAIL reset_popData: got %h, required 0", popData); end
    if (dbgState !== TXN_IDLE) begin testsFailed++; $display("FAIL reset_state: got %0d, required IDLE", dbgState); end
    @(negedge clk);
    nRst = 1'b1;
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] words[3] = '{16'h1111, 16'h2222, 16'h3333};
    bit done, ovf;
    foreach (words[i]) begin
      exp_q.push_back(words[i]);
      doPush(words[i], done, ovf);
      testsRun++;
      if (!done || ovf) begin testsFailed++; $display("FAIL basic_push%0d: done=%b ovf=%b, required 1 0", i, done, ovf); end
    end
    settle();
    testsRun++;
    if (memUsed !== 3'd3) begin testsFailed++; $display("FAIL basic_used3: got %0d, required 3", memUsed); end
    for (int i = 0; i < 3; i++) begin
      doPop(6, done);
      testsRun++;
      if (!done) begin testsFailed++; $display("FAIL basic_pop%0d: no popDone, required one", i); end
    end
    settle();
    testsRun++;
    if (memUsed !== 3'd0) begin testsFailed++; $display("FAIL basic_used0: got %0d, required 0", memUsed); end
  endtask

  task automatic test_overflow_wrap();
    bit done, ovf;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 5; i++) begin
      d = 16'hA000 + 16'(i);
      if (i < 4) exp_q.push_back(d);
      doPush(d, done, ovf);
      testsRun++;
      if (!done || ovf !== (i == 4)) begin
        testsFailed++;
        $display("FAIL ovf_push%0d: done=%b ovf=%b, required 1 %b", i, done, ovf, i == 4);
      end
    end
    settle();
    testsRun++;
    if (memUsed !== 3'd4) begin testsFailed++; $display("FAIL ovf_used4: got %0d, required 4", memUsed); end
    for (int i = 0; i < 4; i++) doPop(6, done);
    for (int lap = 0; lap < 2; lap++) begin
      for (int i = 0; i < 4; i++) begin
        d = 16'($urandom_range(0, 16'hFFFF));
        exp_q.push_back(d);
        doPush(d, done, ovf);
      end
      for (int i = 0; i < 4; i++) doPop(6, done);
    end
    settle();
    testsRun++;
    if (memUsed !== 3'd0) begin testsFailed++; $display("FAIL wrap_used0: got %0d, required 0", memUsed); end
  endtask

  task automatic test_rollback();
    bit done, ovf;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(16'hB000 + 16'(i));
      doPush(16'hB000 + 16'(i), done, ovf);
    end
    doOpen();
    @(negedge clk);
    testsRun++;
    if (txnOpen !== 1'b1 || dbgState !== TXN_OPEN) begin
      testsFailed++; $display("FAIL rb_open: txnOpen=%b state=%0d, required 1 OPEN", txnOpen, dbgState);
    end
    for (int i = 0; i < 2; i++) doPop(6, done);
    settle();
    testsRun++;
    if (memUsed !== 3'd4) begin testsFailed++; $display("FAIL rb_used_open: got %0d, required 4", memUsed); end
    doRollback();
    settle();
    testsRun += 2;
    if (memUsed !== 3'd4) begin testsFailed++; $display("FAIL rb_used_after: got %0d, required 4", memUsed); end
    if (txnOpen !== 1'b0) begin testsFailed++; $display("FAIL rb_txnOpen: got %b, required 0", txnOpen); end
    for (int i = 0; i < 2; i++) doPop(6, done);
    settle();
    testsRun++;
    if (memUsed !== 3'd2) begin testsFailed++; $display("FAIL rb_used2: got %0d, required 2", memUsed); end
    for (int i = 0; i < 2; i++) doPop(6, done);
  endtask

  task automatic test_commit();
    bit done, ovf;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(16'hC000 + 16'(i));
      doPush(16'hC000 + 16'(i), done, ovf);
    end
    doOpen();
    for (int i = 0; i < 4; i++) doPop(6, done);
    settle();
    testsRun++;
    if (memUsed !== 3'd4) begin testsFailed++; $display("FAIL cm_used_open: got %0d, required 4", memUsed); end
    doCommit();
    settle();
    testsRun += 2;
    if (memUsed !== 3'd0) begin testsFailed++; $display("FAIL cm_used0: got %0d, required 0", memUsed); end
    if (txnOpen !== 1'b0) begin testsFailed++; $display("FAIL cm_txnOpen: got %b, required 0", txnOpen); end
    doPop(6, done);
    testsRun++;
    if (done) begin testsFailed++; $display("FAIL cm_pending_pop: popDone seen, required none"); end
  endtask

  task automatic test_same_cycle();
    bit done, ovf;
    // pop together with commit
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(16'hD000 + 16'(i));
      doPush(16'hD000 + 16'(i), done, ovf);
    end
    doOpen();
    txnRead.delete();
    @(posedge clk); #1;
    popRequest = 1'b1;
    commit     = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
    @(negedge clk);
    testsRun++;
    if (popDone !== 1'b1) begin testsFailed++; $display("FAIL sc_pop_commit_done: got %b, required 1", popDone); end
    @(posedge clk); #1;
    popRequest = 1'b0;
    settle();
    testsRun += 2;
    if (memUsed !== 3'd1) begin testsFailed++; $display("FAIL sc_pop_commit_used: got %0d, required 1", memUsed); end
    if (txnOpen !== 1'b0) begin testsFailed++; $display("FAIL sc_pop_commit_txn: got %b, required 0", txnOpen); end
    // pop together with rollback
    doOpen();
    @(posedge clk); #1;
    popRequest = 1'b1;
    rollback   = 1'b1;
    @(posedge clk); #1;
    rollback = 1'b0;
    @(negedge clk);
    testsRun += 2;
    if (popDone !== 1'b0) begin testsFailed++; $display("FAIL sc_pop_rollback_done: got %b, required 0", popDone); end
    if (txnOpen !== 1'b0) begin testsFailed++; $display("FAIL sc_pop_rollback_txn: got %b, required 0", txnOpen); end
    done = 1'b0;
    for (int i = 0; i < 5 && !done; i++) begin
      @(negedge clk);
      if (popDone) done = 1'b1;
    end
    @(posedge clk); #1;
    popRequest = 1'b0;
    testsRun++;
    if (!done) begin testsFailed++; $display("FAIL sc_pop_after_rollback: no popDone, required one"); end
    // commit and rollback together
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(16'hE000 + 16'(i));
      doPush(16'hE000 + 16'(i), done, ovf);
    end
    doOpen();
    doPop(6, done);
    txnRead.delete();
    @(posedge clk); #1;
    commit   = 1'b1;
    rollback = 1'b1;
    @(posedge clk); #1;
    commit   = 1'b0;
    rollback = 1'b0;
    settle();
    testsRun += 2;
    if (memUsed !== 3'd1) begin testsFailed++; $display("FAIL sc_commit_wins_used: got %0d, required 1", memUsed); end
    if (txnOpen !== 1'b0) begin testsFailed++; $display("FAIL sc_commit_wins_txn: got %b, required 0", txnOpen); end
    doPop(6, done);
    settle();
    testsRun++;
    if (memUsed !== 3'd0) begin testsFailed++; $display("FAIL sc_final_used: got %0d, required 0", memUsed); end
  endtask

  task automatic test_reset_midtxn();
    bit done, ovf;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(16'hF000 + 16'(i));
      doPush(16'hF000 + 16'(i), done, ovf);
    end
    doOpen();
    doPop(6, done);
    @(posedge clk); #1;
    pushData    = 16'hF0F0;
    pushRequest = 1'b1;
    @(posedge clk); #2;
    testsRun++;
    if (pushDone !== 1'b1) begin testsFailed++; $display("FAIL mid_pre_pushDone: got %b, required 1", pushDone); end
    nRst = 1'b0;
    #1;
    testsRun += 6;
    if (pushDone !== 1'b0) begin testsFailed++; $display("FAIL mid_pushDone: got %b, required 0", pushDone); end
    if (popDone !== 1'b0) begin testsFailed++; $display("FAIL mid_popDone: got %b, required 0", popDone); end
    if (overflow !== 1'b0) begin testsFailed++; $display("FAIL mid_overflow: got %b, required 0", overflow); end
    if (txnOpen !== 1'b0 || dbgState !== TXN_IDLE) begin
      testsFailed++; $display("FAIL mid_state: txnOpen=%b state=%0d, required 0 IDLE", txnOpen, dbgState);
    end
    if (memUsed !== 3'd0) begin testsFailed++; $display("FAIL mid_memUsed: got %0d, required 0", memUsed); end
    if (popData !== 16'h0) begin testsFailed++; $display("FAIL mid_popData: got %h, required 0", popData); end
    exp_q.delete();
    txnRead.delete();
    pushRequest = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    exp_q.push_back(16'h5A5A);
    doPush(16'h5A5A, done, ovf);
    settle();
    testsRun++;
    if (memUsed !== 3'd1) begin testsFailed++; $display("FAIL mid_after_used1: got %0d, required 1", memUsed); end
    doPop(6, done);
    testsRun++;
    if (!done) begin testsFailed++; $display("FAIL mid_after_pop: no popDone, required one"); end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    nRst        = 1'b0;
    pushData    = '0;
    pushRequest = 1'b0;
    popRequest  = 1'b0;
    open        = 1'b0;
    commit      = 1'b0;
    rollback    = 1'b0;
    test_reset();
    test_basic();
    test_overflow_wrap();
    test_rollback();
    test_commit();
    test_same_cycle();
    test_reset_midtxn();
    repeat (3) @(negedge clk);
    testsRun++;
    if (exp_q.size() != 0) begin
      testsFailed++;
      $display("FAIL leftover_words: %0d words never popped, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
